// File: rtl/dmem_responder_pkg.sv
// Shared configuration for the data-memory responder.
// Contents: bus/array geometry, access-size codes, FSM state encoding and a
// helper that returns the right-aligned data mask for an access size.
package dmem_responder_pkg;

    localparam int          XLEN           = 32;
    localparam logic [31:0] ZERO_32BIT     = 32'h0000_0000;
    localparam logic [31:0] BOOT_DATA_ADDR = 32'h0000_2000;
    localparam int          DATA_RAM_DEPTH = 1024;
    localparam int          DATA_RAM_WIDTH = 32;

    // Access size codes carried on req_size; 2'b11 is illegal.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Right-aligned mask keeping only the bytes of a load of this size.
    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  size_mask = 32'h0000_00FF;
            SIZE_H:  size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_check.sv
// Combinational lane-mask, alignment and range check for one access.
// Ports:
//   addr [XLEN-1:0] in  : byte address of the access
//   size [1:0]      in  : access size code (byte/half/word, 11 illegal)
//   mask [3:0]      out : byte lanes touched; all zero when err is set
//   err             out : out of range, misaligned or illegal size
module dmem_lane_check
    import dmem_responder_pkg::*;
#(
    parameter logic [XLEN-1:0] MEM_BASE  = BOOT_DATA_ADDR,
    parameter int              MEM_DEPTH = DATA_RAM_DEPTH
) (
    input  logic [XLEN-1:0] addr,
    input  logic [1:0]      size,
    output logic [3:0]      mask,
    output logic            err
);

    // One past the last valid byte, computed one bit wider so a window that
    // ends at the top of the address space does not wrap.
    localparam logic [XLEN:0] LIMIT = {1'b0, MEM_BASE} + (XLEN+1)'(4 * MEM_DEPTH);

    logic [1:0] lane;
    logic       out_of_range;
    logic       misaligned;
    logic       bad_size;

    always_comb begin
        lane         = addr[1:0];
        out_of_range = (addr < MEM_BASE) || ({1'b0, addr} >= LIMIT);
        mask         = 4'b0000;
        misaligned   = 1'b0;
        bad_size     = 1'b0;
        case (size)
            SIZE_B: mask = 4'b0001 << lane;
            SIZE_H: begin
                mask       = 4'b0011 << lane;
                misaligned = addr[0];
            end
            SIZE_W: begin
                mask       = 4'b1111;
                misaligned = (lane != 2'b00);
            end
            default: bad_size = 1'b1;
        endcase
        err = out_of_range | misaligned | bad_size;
        // A rejected access must never reach the array, so its mask is cleared.
        if (err) begin
            mask = 4'b0000;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time over a
// valid/ready request channel and answers with a single-cycle response
// pulse a fixed two cycles after the handshake.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake (ready only when idle)
//   req_we, req_addr,
//   req_size, req_wdata      : request fields, captured on the handshake
//   resp_valid               : one-cycle response strobe
//   resp_rdata               : right-aligned, zero-extended load data
//   resp_err                 : request rejected
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter logic [XLEN-1:0] MEM_BASE  = BOOT_DATA_ADDR,
    parameter int              MEM_DEPTH = DATA_RAM_DEPTH,
    parameter int              MEM_WIDTH = DATA_RAM_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e state_reg, state_next;

    logic            we_reg;
    logic [XLEN-1:0] addr_reg;
    logic [1:0]      size_reg;
    logic [XLEN-1:0] wdata_reg;

    logic [MEM_WIDTH-1:0] mem [0:MEM_DEPTH-1];
    logic [MEM_WIDTH-1:0] rword_reg;

    logic [3:0]       lane_mask;
    logic             lane_err;
    logic [XLEN-1:0]  offset;
    logic [IDX_W-1:0] word_idx;
    logic [4:0]       shamt;
    logic [XLEN-1:0]  wdata_lanes;
    logic [XLEN-1:0]  load_data;
    logic             unused_offset_bits;

    dmem_lane_check #(
        .MEM_BASE  (MEM_BASE),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_lane_check (
        .addr (addr_reg),
        .size (size_reg),
        .mask (lane_mask),
        .err  (lane_err)
    );

    // Everything downstream of the handshake works from the captured request.
    assign offset             = addr_reg - MEM_BASE;
    assign word_idx           = offset[IDX_W+1:2];
    assign shamt              = {addr_reg[1:0], 3'b000};
    assign wdata_lanes        = wdata_reg << shamt;
    assign load_data          = (rword_reg >> shamt) & size_mask(size_reg);
    assign unused_offset_bits = &{1'b0, offset[XLEN-1:IDX_W+2], offset[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Outputs are also qualified by rst so the idle/zero state is visible
    // for the whole reset period, not just after the first reset edge.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = ~rst;
                if (req_valid) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP: begin
                resp_valid = ~rst;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            size_reg  <= 2'b00;
            wdata_reg <= '0;
        end else if (state_reg == ST_IDLE && req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            size_reg  <= req_size;
            wdata_reg <= req_wdata;
        end
    end

    // Array contents are deliberately not reset. A reset coinciding with the
    // access edge suppresses the write so an aborted store leaves no trace.
    always_ff @(posedge clk) begin
        if (state_reg == ST_ACCESS) begin
            if (!rst && we_reg) begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_mask[i]) begin
                        mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                    end
                end
            end
            rword_reg <= mem[word_idx];
        end
    end

    assign resp_rdata = (resp_valid && !we_reg && !lane_err) ? load_data : ZERO_32BIT;
    assign resp_err   = resp_valid & lane_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// byte-addressed behavioural model.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(
        .MEM_BASE  (BASE),
        .MEM_DEPTH (DEPTH),
        .MEM_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: a flat byte array ----------------
    logic [7:0] mm [0:4*DEPTH-1];

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        longint la = longint'(a);
        return (la < longint'(BASE)) || (la >= longint'(BASE) + 4*DEPTH) ||
               (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] r = 32'h0;
        int off = int'(a - BASE);
        for (int b = 0; b < (1 << sz); b++) r = r | (32'(mm[off+b]) << (8*b));
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int off = int'(a - BASE);
        for (int b = 0; b < (1 << sz); b++) mm[off+b] = d[8*b +: 8];
    endtask

    // ---------------- per-cycle compare process ----------------
    logic        busy = 1'b0;
    int          hs_cyc = 0;
    int          hs_count = 0;
    int          resp_seen = 0;
    logic        p_we, p_err;
    logic [31:0] p_addr, p_wdata, p_rd;
    logic [1:0]  p_size;

    always @(negedge clk) begin : monitor
        int age;
        logic e_v;
        if (rst) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_resp_rdata", resp_rdata, 0);
            check("rst_resp_err", resp_err, 0);
            busy = 1'b0;  // anything in flight is aborted
        end else begin
            age = cyc - hs_cyc;
            e_v = busy && (age == 2);
            check("req_ready", req_ready, !busy);
            check("resp_valid", resp_valid, e_v);
            check("resp_rdata", resp_rdata, e_v ? p_rd : 32'h0);
            check("resp_err", resp_err, e_v ? p_err : 1'b0);
            if (resp_valid) resp_seen++;
            // The write lands on the edge ending the cycle one after the handshake.
            if (busy && age == 1 && p_we && !p_err) model_store(p_addr, p_size, p_wdata);
            if (busy && age == 2) begin
                busy = 1'b0;
            end else if (!busy && req_valid) begin
                busy    = 1'b1;
                hs_cyc  = cyc;
                hs_count++;
                p_we    = req_we;
                p_addr  = req_addr;
                p_size  = req_size;
                p_wdata = req_wdata;
                p_err   = model_err(req_addr, req_size);
                p_rd    = (req_we || p_err) ? 32'h0 : model_load(req_addr, req_size);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        int n = 0;
        logic got = 1'b0;
        rd = 32'h0; er = 1'b0; lat = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
        do begin
            @(negedge clk); n++;
        end while (!req_ready && n < 10);
        if (!req_ready) check("handshake_timeout", 0, 1);
        @(posedge clk); #1;
        // Scramble the request fields: the DUT must have captured them already.
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_size = 2'($urandom); req_wdata = $urandom;
        for (int i = 1; i <= 6 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1; lat = i; rd = resp_rdata; er = resp_err;
            end
        end
        if (!got) check("resp_timeout", 0, 1);
        $display("req we=%0d addr=%08h size=%0d wdata=%08h -> rdata=%08h err=%0d lat=%0d",
                 we, a, sz, wd, rd, er, lat);
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          base_hs, base_resp;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_size = 2'b00; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // Word store then load.
        do_req(1, BASE+8, 2'b10, 32'hDEADBEEF, rd, er, lat);
        check("st_w_rdata", rd, 0); check("st_w_err", er, 0); check("st_w_lat", lat, 2);
        do_req(0, BASE+8, 2'b10, 32'h0, rd, er, lat);
        check("ld_w_rdata", rd, 32'hDEADBEEF); check("ld_w_err", er, 0); check("ld_w_lat", lat, 2);

        // Byte store into lane 1.
        do_req(1, BASE+9, 2'b00, 32'h0000005A, rd, er, lat);
        do_req(0, BASE+8, 2'b10, 32'h0, rd, er, lat);
        check("ld_w_after_sb", rd, 32'hDEAD5AEF);
        do_req(0, BASE+9, 2'b00, 32'h0, rd, er, lat);
        check("ld_b_lane1", rd, 32'h0000005A);

        // Misaligned half accesses.
        do_req(1, BASE+0, 2'b10, 32'h01020304, rd, er, lat);
        do_req(0, BASE+3, 2'b01, 32'h0, rd, er, lat);
        check("ld_h_mis_err", er, 1); check("ld_h_mis_rdata", rd, 0);
        do_req(1, BASE+3, 2'b01, 32'h0000FFFF, rd, er, lat);
        check("st_h_mis_err", er, 1);
        do_req(0, BASE+0, 2'b10, 32'h0, rd, er, lat);
        check("word_unchanged", rd, 32'h01020304);
        do_req(0, BASE+2, 2'b01, 32'h0, rd, er, lat);
        check("ld_h_lane2", rd, 32'h00000102);

        // Range boundaries and illegal size.
        do_req(1, BASE + 4*DEPTH, 2'b10, 32'hCAFEF00D, rd, er, lat);
        check("st_past_end_err", er, 1);
        do_req(0, BASE - 4, 2'b10, 32'h0, rd, er, lat);
        check("ld_below_base_err", er, 1); check("ld_below_base_rdata", rd, 0);
        do_req(0, BASE + 4*DEPTH - 4, 2'b11, 32'h0, rd, er, lat);
        check("illegal_size_err", er, 1);
        do_req(0, BASE+8, 2'b10, 32'h0, rd, er, lat);
        check("no_change_after_err", rd, 32'hDEAD5AEF);

        // Continuous req_valid: one handshake every 3 cycles.
        @(posedge clk); #1;
        base_hs = hs_count;
        req_valid = 1'b1; req_we = 1'b0; req_addr = BASE+8; req_size = 2'b10;
        repeat (12) @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        check("stream_handshakes", hs_count - base_hs, 4);

        // Reset in the access cycle aborts a store.
        do_req(1, BASE+16, 2'b10, 32'h22222222, rd, er, lat);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = BASE+16; req_size = 2'b10; req_wdata = 32'h11111111;
        @(negedge clk);
        check("abort_ready_before_hs", req_ready, 1);
        base_resp = resp_seen;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", req_ready, 1);
        repeat (3) @(negedge clk);
        check("abort_no_resp", resp_seen - base_resp, 0);
        do_req(0, BASE+16, 2'b10, 32'h0, rd, er, lat);
        check("abort_kept_old", rd, 32'h22222222);

        // Define every word, then random traffic across and around the window.
        for (int w = 0; w < DEPTH; w++) do_req(1, BASE + 4*w, 2'b10, $urandom, rd, er, lat);
        for (int t = 0; t < 250; t++) begin
            do_req(1'($urandom), BASE - 8 + $urandom_range(0, 4*DEPTH + 15),
                   2'($urandom_range(0, 3)), $urandom, rd, er, lat);
            check("rand_lat", lat, 2);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
